// File: rtl/deck_controller.sv
// Card deck sequencer: builds an ordered 52-card deck in external RAM, Fisher-Yates
// shuffles it in place with a seeded Galois LFSR, then deals cards on request.
module deck_controller #(
  parameter int          DECK_SIZE    = 52,
  parameter int          ADDR_W       = 6,
  parameter int          CARD_W       = 4,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       seed,
  input  logic              deal_req,
  output logic [CARD_W-1:0] card,
  output logic              card_valid,
  output logic              deal_err,
  output logic [ADDR_W-1:0] cards_left,
  output logic              busy,
  output logic              ready,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [CARD_W-1:0] ram_data_in,
  input  logic [CARD_W-1:0] ram_data_out
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT      = 4'd1,
    PICK      = 4'd2,
    RD_I      = 4'd3,
    RD_J      = 4'd4,
    WAIT_J    = 4'd5,
    WR_I      = 4'd6,
    WR_J      = 4'd7,
    READY     = 4'd8,
    DEAL_RD   = 4'd9,
    DEAL_WAIT = 4'd10
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DECK_SIZE - 1);
  localparam logic [ADDR_W-1:0] FULL_DECK = ADDR_W'(DECK_SIZE);

  state_t              state_q;
  logic [15:0]         lfsr_q;
  logic [ADDR_W-1:0]   k_q;
  logic [3:0]          rank_q;
  logic [ADDR_W-1:0]   i_q;
  logic [ADDR_W-1:0]   j_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [CARD_W-1:0]   vi_q;
  logic [CARD_W-1:0]   card_q;
  logic                card_valid_q;
  logic                deal_err_q;
  logic [ADDR_W-1:0]   cards_left_q;
  logic                busy_q;
  logic                ready_q;
  logic                ram_wr_en_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [CARD_W-1:0]   ram_data_in_q;

  logic [15:0]         lfsr_d;
  logic [ADDR_W-1:0]   mask_d;
  logic [ADDR_W-1:0]   r_d;
  logic [3:0]          rank_d;

  // Galois right-shift step, taps 16'hB400
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Smallest all-ones mask covering v
  function automatic logic [ADDR_W-1:0] range_mask(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] m;
    m = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      if (m < v) m = {m[ADDR_W-2:0], 1'b1};
      else       m = m;
    end
    return m;
  endfunction

  // Rank 0..12 maps to card value 1..9 then 10 for 10/J/Q/K
  function automatic logic [CARD_W-1:0] init_card(input logic [3:0] rank);
    return (rank >= 4'd9) ? CARD_W'(10) : CARD_W'(rank + 4'd1);
  endfunction

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
    mask_d = range_mask(i_q);
    r_d    = lfsr_q[ADDR_W-1:0] & mask_d;
    if (rank_q == 4'd12) rank_d = 4'd0;
    else                 rank_d = rank_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      lfsr_q        <= DEFAULT_SEED;
      k_q           <= '0;
      rank_q        <= 4'd0;
      i_q           <= '0;
      j_q           <= '0;
      ptr_q         <= '0;
      vi_q          <= '0;
      card_q        <= '0;
      card_valid_q  <= 1'b0;
      deal_err_q    <= 1'b0;
      cards_left_q  <= '0;
      busy_q        <= 1'b0;
      ready_q       <= 1'b0;
      ram_wr_en_q   <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
    end else if (start) begin
      // Restart from any state; the first INIT write is presented right away
      state_q       <= INIT;
      lfsr_q        <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
      k_q           <= '0;
      rank_q        <= 4'd0;
      card_valid_q  <= 1'b0;
      deal_err_q    <= 1'b0;
      cards_left_q  <= '0;
      busy_q        <= 1'b1;
      ready_q       <= 1'b0;
      ram_wr_en_q   <= 1'b1;
      ram_addr_q    <= '0;
      ram_data_in_q <= init_card(4'd0);
    end else begin
      card_valid_q <= 1'b0;
      deal_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        INIT: begin
          if (k_q == LAST_IDX) begin
            ram_wr_en_q <= 1'b0;
            i_q         <= LAST_IDX;
            state_q     <= PICK;
          end else begin
            k_q           <= k_q + ADDR_W'(1);
            rank_q        <= rank_d;
            ram_addr_q    <= k_q + ADDR_W'(1);
            ram_data_in_q <= init_card(rank_d);
          end
        end
        PICK: begin
          lfsr_q <= lfsr_d;
          if (r_d <= i_q) begin
            j_q        <= r_d;
            ram_addr_q <= i_q;
            state_q    <= RD_I;
          end else begin
            state_q <= PICK;
          end
        end
        RD_I: begin
          ram_addr_q <= j_q;
          state_q    <= RD_J;
        end
        RD_J: begin
          vi_q    <= ram_data_out;
          state_q <= WAIT_J;
        end
        WAIT_J: begin
          ram_wr_en_q   <= 1'b1;
          ram_addr_q    <= i_q;
          ram_data_in_q <= ram_data_out;
          state_q       <= WR_I;
        end
        WR_I: begin
          ram_addr_q    <= j_q;
          ram_data_in_q <= vi_q;
          state_q       <= WR_J;
        end
        WR_J: begin
          ram_wr_en_q <= 1'b0;
          if (i_q == ADDR_W'(1)) begin
            ptr_q        <= '0;
            cards_left_q <= FULL_DECK;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
            state_q      <= READY;
          end else begin
            i_q     <= i_q - ADDR_W'(1);
            state_q <= PICK;
          end
        end
        READY: begin
          if (deal_req && (cards_left_q != '0)) begin
            ram_addr_q <= ptr_q;
            ready_q    <= 1'b0;
            state_q    <= DEAL_RD;
          end else if (deal_req) begin
            deal_err_q <= 1'b1;
          end else begin
            state_q <= READY;
          end
        end
        DEAL_RD: begin
          state_q <= DEAL_WAIT;
        end
        DEAL_WAIT: begin
          card_q       <= ram_data_out;
          card_valid_q <= 1'b1;
          ptr_q        <= ptr_q + ADDR_W'(1);
          if (cards_left_q != '0) cards_left_q <= cards_left_q - ADDR_W'(1);
          else                    cards_left_q <= '0;
          ready_q      <= 1'b1;
          state_q      <= READY;
        end
        default: begin
          state_q     <= IDLE;
          ram_wr_en_q <= 1'b0;
          busy_q      <= 1'b0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign card        = card_q;
  assign card_valid  = card_valid_q;
  assign deal_err    = deal_err_q;
  assign cards_left  = cards_left_q;
  assign busy        = busy_q;
  assign ready       = ready_q;
  assign ram_wr_en   = ram_wr_en_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_data_in_q;

endmodule
